// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage with a registered MEM/WB output.
//
// Non-memory instructions pass wd/wreg/wdata through in one cycle. Loads and
// stores (mem_op 1..8) run a req/ack transaction on a 32-bit big-endian bus
// and stall upstream until the bus acknowledges.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   valid_input                instruction present in the MEM slot
//   wd_input/wreg_input        destination register / write enable
//   wdata_input                ALU result (effective address for memory ops)
//   mem_op                     0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW
//   store_data                 store operand (low byte/halfword used for SB/SH)
//   bus_req/we/addr/sel/wdata  registered bus request side
//   bus_rdata/bus_ack          bus response (ack is a one-cycle pulse)
//   stall_req                  combinational upstream hold
//   wd/wreg/wdata_output       registered write-back triple
//   align_err                  one-cycle pulse on a misaligned access
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_input,
    input  logic [4:0]  wd_input,
    input  logic        wreg_input,
    input  logic [31:0] wdata_input,
    input  logic [3:0]  mem_op,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_req,
    output logic [4:0]  wd_output,
    output logic        wreg_output,
    output logic [31:0] wdata_output,
    output logic        align_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t     state;
    logic [3:0] op_q;    // opcode of the in-flight transaction
    logic [1:0] off_q;   // byte offset of the in-flight transaction

    logic       is_mem, is_byte, is_half, is_word, is_store, misalign;
    logic [1:0] off;
    logic [3:0] sel_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;

    // Request-side decode of the current input.
    always_comb begin
        off      = wdata_input[1:0];
        is_mem   = valid_input && (mem_op >= OP_LB) && (mem_op <= OP_SW);
        is_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
        is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
        is_store = (mem_op >= OP_SB);
        misalign = (is_half && off[0]) || (is_word && (off != 2'b00));

        // Big-endian lanes: sel[3] is byte offset 0 (bits 31:24).
        sel_c   = 4'b1111;
        wdata_c = store_data;
        if (is_byte) begin
            sel_c   = 4'b1000 >> off;
            wdata_c = {4{store_data[7:0]}};
        end else if (is_half) begin
            sel_c   = off[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{store_data[15:0]}};
        end
    end

    // Load-data lane extraction, driven by the registered op/offset.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = bus_rdata[8'd31 - {3'd0, off_q, 3'd0} -: 8];
        h = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        load_c = bus_rdata;
        case (op_q)
            OP_LB:   load_c = {{24{b[7]}}, b};
            OP_LBU:  load_c = {24'd0, b};
            OP_LH:   load_c = {{16{h[15]}}, h};
            OP_LHU:  load_c = {16'd0, h};
            default: load_c = bus_rdata;
        endcase
    end

    assign stall_req = ((state == IDLE) && is_mem && !misalign) ||
                       ((state == BUSY) && !bus_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= 4'd0;
            off_q        <= 2'd0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_sel      <= 4'd0;
            bus_wdata    <= 32'd0;
            wd_output    <= 5'd0;
            wreg_output  <= 1'b0;
            wdata_output <= 32'd0;
            align_err    <= 1'b0;
        end else begin
            align_err <= 1'b0;
            case (state)
                IDLE: begin
                    wd_output    <= wd_input;
                    wdata_output <= wdata_input;
                    if (is_mem && misalign) begin
                        // No bus cycle, no stall: flag and kill the write.
                        wreg_output <= 1'b0;
                        align_err   <= 1'b1;
                    end else if (is_mem) begin
                        bus_req     <= 1'b1;
                        bus_we      <= is_store;
                        bus_addr    <= {wdata_input[31:2], 2'b00};
                        bus_sel     <= sel_c;
                        bus_wdata   <= wdata_c;
                        op_q        <= mem_op;
                        off_q       <= off;
                        wreg_output <= 1'b0;
                        state       <= BUSY;
                    end else begin
                        wreg_output <= valid_input && wreg_input;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        wd_output <= wd_input;
                        state     <= IDLE;
                        if (op_q >= OP_SB) begin
                            wreg_output  <= 1'b0;
                            wdata_output <= 32'd0;
                        end else begin
                            wreg_output  <= wreg_input;
                            wdata_output <= load_c;
                        end
                    end else begin
                        wreg_output <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_input;
    logic [4:0]  wd_input;
    logic        wreg_input;
    logic [31:0] wdata_input;
    logic [3:0]  mem_op;
    logic [31:0] store_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_req;
    logic [4:0]  wd_output;
    logic        wreg_output;
    logic [31:0] wdata_output;
    logic        align_err;

    int total = 0;
    int fails = 0;

    mem_access dut (
        .clk(clk), .reset(reset), .valid_input(valid_input),
        .wd_input(wd_input), .wreg_input(wreg_input), .wdata_input(wdata_input),
        .mem_op(mem_op), .store_data(store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_req(stall_req), .wd_output(wd_output),
        .wreg_output(wreg_output), .wdata_output(wdata_output),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] wd, input logic wr,
                         input logic [31:0] wdat, input logic [3:0] op,
                         input logic [31:0] sd);
        valid_input = v; wd_input = wd; wreg_input = wr;
        wdata_input = wdat; mem_op = op; store_data = sd;
        #1;
    endtask

    initial begin
        reset = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_wd", {27'd0, wd_output}, 32'd0);
        chk("rst_wdata", wdata_output, 32'd0);
        chk("rst_align", {31'd0, align_err}, 32'd0);

        // Non-memory pass-through.
        drive(1'b1, 5'd5, 1'b1, 32'h1234, 4'd0, 32'd0);
        chk("alu_stall", {31'd0, stall_req}, 32'd0);
        tick();
        chk("alu_wd", {27'd0, wd_output}, 32'd5);
        chk("alu_wreg", {31'd0, wreg_output}, 32'd1);
        chk("alu_wdata", wdata_output, 32'h1234);
        chk("alu_bus_req", {31'd0, bus_req}, 32'd0);
        drive(1'b0, 5'd5, 1'b1, 32'h1234, 4'd0, 32'd0);
        tick();
        chk("novalid_wreg", {31'd0, wreg_output}, 32'd0);

        // LB 0x103, ack in cycle 1.
        drive(1'b1, 5'd7, 1'b1, 32'h103, 4'd1, 32'd0);
        chk("lb_stall_c0", {31'd0, stall_req}, 32'd1);
        tick();
        chk("lb_req", {31'd0, bus_req}, 32'd1);
        chk("lb_we", {31'd0, bus_we}, 32'd0);
        chk("lb_sel", {28'd0, bus_sel}, 32'b0001);
        chk("lb_addr", bus_addr, 32'h100);
        chk("lb_bubble", {31'd0, wreg_output}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h000000F0; #1;
        chk("lb_stall_c1", {31'd0, stall_req}, 32'd0);
        tick();
        bus_ack = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("lb_req_off", {31'd0, bus_req}, 32'd0);
        chk("lb_wd", {27'd0, wd_output}, 32'd7);
        chk("lb_wreg", {31'd0, wreg_output}, 32'd1);
        chk("lb_data", wdata_output, 32'hFFFFFFF0);

        // LHU 0x200, ack in cycle 4.
        drive(1'b1, 5'd9, 1'b1, 32'h200, 4'd4, 32'd0);
        chk("lhu_stall_c0", {31'd0, stall_req}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lhu_stall_wait", {31'd0, stall_req}, 32'd1);
            chk("lhu_sel_hold", {28'd0, bus_sel}, 32'b1100);
            chk("lhu_addr_hold", bus_addr, 32'h200);
            chk("lhu_req_hold", {31'd0, bus_req}, 32'd1);
        end
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h8001BEEF; #1;
        chk("lhu_stall_ack", {31'd0, stall_req}, 32'd0);
        tick();
        bus_ack = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("lhu_data", wdata_output, 32'h00008001);
        chk("lhu_wreg", {31'd0, wreg_output}, 32'd1);

        // LH 0x302, sign extension of the low halfword.
        drive(1'b1, 5'd3, 1'b1, 32'h302, 4'd3, 32'd0);
        tick();
        chk("lh_sel", {28'd0, bus_sel}, 32'b0011);
        bus_ack = 1'b1; bus_rdata = 32'h12348000; #1;
        tick();
        bus_ack = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("lh_data", wdata_output, 32'hFFFF8000);

        // SB 0x12.
        drive(1'b1, 5'd4, 1'b1, 32'h12, 4'd6, 32'h000000AB);
        tick();
        chk("sb_we", {31'd0, bus_we}, 32'd1);
        chk("sb_sel", {28'd0, bus_sel}, 32'b0010);
        chk("sb_wdata", bus_wdata, 32'hABABABAB);
        bus_ack = 1'b1; #1;
        tick();
        bus_ack = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("sb_wreg", {31'd0, wreg_output}, 32'd0);
        chk("sb_wdata_out", wdata_output, 32'd0);

        // SH 0x2.
        drive(1'b1, 5'd4, 1'b1, 32'h2, 4'd7, 32'h1234CDEF);
        tick();
        chk("sh_sel", {28'd0, bus_sel}, 32'b0011);
        chk("sh_wdata", bus_wdata, 32'hCDEFCDEF);
        bus_ack = 1'b1; #1;
        tick();
        bus_ack = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);

        // Misaligned LW 0x102.
        drive(1'b1, 5'd6, 1'b1, 32'h102, 4'd5, 32'd0);
        chk("lw_mis_stall", {31'd0, stall_req}, 32'd0);
        tick();
        chk("lw_mis_err", {31'd0, align_err}, 32'd1);
        chk("lw_mis_req", {31'd0, bus_req}, 32'd0);
        chk("lw_mis_wreg", {31'd0, wreg_output}, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        tick();
        chk("lw_mis_err_pulse", {31'd0, align_err}, 32'd0);

        // SW 0x40 aborted by reset in cycle 2, then a late ack.
        drive(1'b1, 5'd8, 1'b1, 32'h40, 4'd8, 32'hDEADBEEF);
        tick();
        chk("sw_sel", {28'd0, bus_sel}, 32'b1111);
        chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("abort_req", {31'd0, bus_req}, 32'd0);
        chk("abort_we", {31'd0, bus_we}, 32'd0);
        chk("abort_addr", bus_addr, 32'd0);
        chk("abort_stall", {31'd0, stall_req}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF; #1;
        chk("late_ack_stall", {31'd0, stall_req}, 32'd0);
        tick();
        bus_ack = 1'b0;
        chk("late_ack_wreg", {31'd0, wreg_output}, 32'd0);
        chk("late_ack_wdata", wdata_output, 32'd0);
        chk("late_ack_req", {31'd0, bus_req}, 32'd0);

        // The stage still works after the aborted transaction.
        drive(1'b1, 5'd2, 1'b1, 32'h10, 4'd5, 32'd0);
        chk("post_stall", {31'd0, stall_req}, 32'd1);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
        tick();
        bus_ack = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("post_lw_data", wdata_output, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage with a registered MEM/WB output. Takes the execute stage's write-back triple (`wd`/`wreg`/`wdata`) plus a load/store opcode and store data. Non-memory instructions pass through in one cycle. Loads and stores run a request/acknowledge transaction on a 32-bit big-endian data bus and stall the pipeline until the bus acknowledges.

## Interface
Parameters:
- none; widths fixed: data 32, register address 5, mem_op 4.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `valid_input`  in  1  an instruction occupies the MEM slot this cycle
- `wd_input`  in  5  destination register address
- `wreg_input`  in  1  register write enable
- `wdata_input`  in  32  ALU result; for memory ops, the effective address
- `mem_op`  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- `store_data`  in  32  store operand; the byte/halfword is taken from the low bits
- `bus_req`  out  1  bus request (registered)
- `bus_we`  out  1  1 = write (registered)
- `bus_addr`  out  32  word address, bits [1:0] = 0 (registered)
- `bus_sel`  out  4  byte lanes; bit 3 = bits 31:24 = byte offset 0 (registered)
- `bus_wdata`  out  32  lane-replicated store data (registered)
- `bus_rdata`  in  32  read data, valid when `bus_ack` = 1
- `bus_ack`  in  1  transaction complete; single-cycle pulse
- `stall_req`  out  1  combinational; holds upstream stages
- `wd_output`  out  5  to write-back (registered)
- `wreg_output`  out  1  to write-back (registered)
- `wdata_output`  out  32  to write-back (registered)
- `align_err`  out  1  one-cycle pulse on a misaligned access (registered)

## Operation
- States: IDLE, BUSY.
- A memory op is `valid_input` with `mem_op` in 1-8.
- Alignment rules:
  - Halfword ops (LH/LHU/SH) require addr[0] = 0.
  - Word ops (LW/SW) require addr[1:0] = 0.
  - A misaligned op issues no bus cycle. It registers `align_err` = 1 and `wreg_output` = 0, does not stall, and stays in IDLE.
- IDLE, non-memory op or `valid_input` = 0:
  - Register `wd`/`wreg`/`wdata` straight through.
  - When `valid_input` = 0, `wreg_output` = 0.
- IDLE, aligned memory op:
  - `stall_req` = 1.
  - Load the bus registers and set `bus_req` = 1. `bus_we` = 1 for SB/SH/SW.
  - Register a bubble (`wreg_output` = 0) and go to BUSY.
- Byte-lane selection from addr[1:0] (big-endian):
  - byte: 00→1000, 01→0100, 10→0010, 11→0001
  - halfword: 00→1100, 10→0011
  - word: 1111
- Store data replication:
  - SB: `{4{b}}`
  - SH: `{2{h}}`
  - SW: the 32-bit word as-is
- BUSY with `bus_ack` = 0: `stall_req` = 1, all bus registers held, bubble registered.
- BUSY with `bus_ack` = 1:
  - `stall_req` = 0; `bus_req` = 0 at the next edge; return to IDLE.
  - Register `wd_input`.
  - Loads: `wreg_output` = `wreg_input`, `wdata_output` = lane-extracted `bus_rdata`. LB/LH sign-extend, LBU/LHU zero-extend.
  - Stores: `wreg_output` = 0, `wdata_output` = 0.
- Upstream holds every input stable while `stall_req` = 1. The instruction seen in IDLE after completion is always a new one.
- `bus_ack` while IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE. Reset takes priority over everything, including an in-flight transaction. A late `bus_ack` after reset is ignored.
- Non-memory latency: 1 cycle, no stall.
- Memory op, input in cycle 0:
  - `stall_req` high in cycle 0.
  - `bus_req` high from cycle 1.
  - `bus_ack` sampled from cycle 1 on.
  - With ack in cycle k: `stall_req` low in cycle k; result on the outputs and `bus_req` low after the cycle-k edge.
  - Minimum latency 2 cycles.
- `stall_req` = (IDLE & aligned memory op) | (BUSY & !`bus_ack`).
- `align_err` lasts exactly one cycle.

## Test plan
- After reset, non-memory op wd=5, wreg=1, wdata=0x1234 → next cycle outputs 5/1/0x1234; `stall_req` never asserts; `bus_req` stays 0.
- LB addr 0x103, `bus_rdata` 0x000000F0, ack in cycle 1 → `bus_sel` 0001, `bus_addr` 0x100, `wdata_output` 0xFFFFFFF0; stall in cycle 0 only.
- LHU addr 0x200, rdata 0x8001xxxx, ack delayed 3 cycles → `stall_req` high cycles 0-3; `wdata_output` 0x00008001; bus registers stable throughout.
- SB addr 0x12, `store_data` 0xAB → `bus_we` 1, `bus_sel` 0010, `bus_wdata` 0xABABABAB, `wreg_output` 0.
- LW addr 0x102 → `align_err` pulse, no `bus_req`, no stall, `wreg_output` 0.
- Reset in cycle 2 of a pending SW, then ack → all outputs 0, IDLE, ack ignored.
